// File: rtl/iq_sample_fifo_p.sv
// Parametrised I/Q sample FIFO with a first-word-fall-through read port.
// Count is the single source of truth for the status flags. The sticky error
// flags record dropped pushes and pulls made while empty.
module iq_sample_fifo_p #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AF_TH  = 6,
    parameter int unsigned AE_TH  = 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     PushIn,
    input  logic [DATA_W-1:0]        SampI,
    input  logic [DATA_W-1:0]        SampQ,
    input  logic                     PullOut,
    output logic [DATA_W-1:0]        OutI,
    output logic [DATA_W-1:0]        OutQ,
    output logic                     OutValid,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic                     AlmostFull,
    output logic                     AlmostEmpty,
    output logic                     Overflow,
    output logic                     Underflow,
    input  logic                     ErrClr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [2*DATA_W-1:0]   mem_q [DEPTH];

    logic                  is_full;
    logic                  is_empty;
    logic                  push_ok;
    logic                  pull_ok;
    logic [2*DATA_W-1:0]   head;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign push_ok  = PushIn & (~is_full | PullOut);
    assign pull_ok  = PullOut & ~is_empty;
    assign head     = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q & ~ErrClr;
        unf_d    = unf_q & ~ErrClr;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pull_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push_ok && !pull_ok) begin
            count_d = count_q + CW'(1);
        end else if (pull_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        // A new error event wins over a same-cycle clear.
        if (PushIn && is_full && !PullOut) begin
            ovf_d = 1'b1;
        end
        if (PullOut && is_empty) begin
            unf_d = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Sample storage; deliberately not reset, writes are blocked during reset.
    always_ff @(posedge Clk) begin
        if (Reset_n && push_ok) begin
            mem_q[wr_ptr_q] <= {SampI, SampQ};
        end
    end

    // Output decode; the head is masked to zero when empty so unwritten
    // storage never reaches the outputs.
    always_comb begin
        OutI        = '0;
        OutQ        = '0;
        if (!is_empty) begin
            OutI = head[2*DATA_W-1:DATA_W];
            OutQ = head[DATA_W-1:0];
        end
        OutValid    = ~is_empty;
        Count       = count_q;
        Full        = is_full;
        Empty       = is_empty;
        AlmostFull  = (count_q >= CW'(AF_TH));
        AlmostEmpty = (count_q <= CW'(AE_TH));
        Overflow    = ovf_q;
        Underflow   = unf_q;
    end

endmodule
